fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of write requesters, range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: FIFO write data width.
REQ-003 SHALL have parameter MAX_BURST, default 8: maximum beats per grant, range 1..255.
REQ-004 SHALL have port wr_clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits: bit i high means requester i presents a beat.
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: requester i data occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_last, input, NUM_REQ bits: bit i marks the final beat of requester i's packet.
REQ-009 SHALL have port req_ready, output, NUM_REQ bits: bit i high means requester i's beat is accepted this cycle.
REQ-010 SHALL have port Wr_full, input, 1 bit: full flag from the FIFO write-side address generator.
REQ-011 SHALL have port Wr_en, output, 1 bit: FIFO write enable.
REQ-012 SHALL have port wr_data, output, DATA_WIDTH bits: FIFO write data.
REQ-013 SHALL have port grant_id, output, clog2(NUM_REQ) bits: index of the current or most recent grantee.
REQ-014 SHALL have port busy, output, 1 bit: high while in state BURST.

Function
REQ-015 SHALL implement a two-state FSM with states IDLE and BURST, held in registers.
REQ-016 In IDLE with any req_valid bit set, SHALL pick a grantee round-robin, searching upward from (last_grant+1) mod NUM_REQ.
REQ-017 On that pick, SHALL load grant_id and clear beat_cnt at the clock edge, and enter BURST on the next cycle.
REQ-018 In IDLE with no req_valid bit set, SHALL remain in IDLE and leave grant_id unchanged.
REQ-019 SHALL drive Wr_en = busy & req_valid[grant_id] & ~Wr_full, combinationally.
REQ-020 SHALL drive req_ready[grant_id] = busy & ~Wr_full; every other req_ready bit SHALL be 0.
REQ-021 SHALL drive wr_data = req_data slice of grant_id at all times; its value is don't-care while Wr_en is 0.
REQ-022 A beat SHALL transfer exactly when Wr_en = 1; each transfer SHALL increment beat_cnt by 1.
REQ-023 beat_cnt SHALL be clog2(MAX_BURST+1) bits wide and SHALL never exceed MAX_BURST.
REQ-024 A burst SHALL end on a transfer with req_last[grant_id] = 1, or on the transfer that brings beat_cnt to MAX_BURST, whichever comes first.
REQ-025 At burst end, SHALL go to IDLE next cycle and set last_grant to grant_id.
REQ-026 Requester 1 SHALL be grantable on the first IDLE cycle after a burst by requester 0 ends, so there are no back-to-back grants to the same requester while others are valid.
REQ-027 In BURST with Wr_full = 1, SHALL stall: no transfer, beat_cnt held, grant held, with no timeout.
REQ-028 In BURST with req_valid[grant_id] = 0, SHALL hold the grant (packet lock) until a terminating transfer occurs.
REQ-029 Valid bits of non-granted requesters SHALL have no effect during BURST.
REQ-030 Grant latency SHALL be 1 cycle (IDLE pick to BURST); the first beat can transfer in the first BURST cycle.
REQ-031 Between bursts there SHALL be exactly one IDLE cycle minimum (arbitration bubble).

Reset
REQ-032 reset = 1 at a rising edge SHALL force state IDLE, beat_cnt = 0, grant_id = 0, last_grant = NUM_REQ-1.
REQ-033 While reset is high, SHALL force Wr_en = 0, req_ready = 0 and busy = 0 combinationally.
REQ-034 Reset asserted mid-burst SHALL abandon the burst; after reset, requester 0 has first priority.

Verification
REQ-035 Reset, then req_valid = 4'b1111 with req_last = 1 on every beat -> grants in order 0,1,2,3,0, one beat each, each separated by one IDLE cycle.
REQ-036 Requester 2 alone, 20-beat packet with req_last only on beat 20, MAX_BURST = 8 -> bursts of 8, 8, 4 beats, grant_id = 2 each time, with IDLE gaps between.
REQ-037 Wr_full = 1 for 3 cycles in mid-burst -> Wr_en = 0 and req_ready = 0 for those cycles, beat_cnt frozen, and no beat lost or duplicated in FIFO order.
REQ-038 Grantee drops req_valid for 2 cycles in mid-packet while others request -> grant held, Wr_en = 0, and the burst resumes and finishes with the same grant_id.
REQ-039 Reset asserted during beat 3 of a burst by requester 1 -> next cycle busy = 0, Wr_en = 0; the first grant after reset goes to requester 0 if it is valid.
REQ-040 Scoreboard check over a random stream -> FIFO contents equal the concatenation of transferred packets, with per-requester order preserved.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter that merges packet bursts from
// several requesters into one FIFO write port, holding each grant until the
// packet ends or MAX_BURST beats have been written.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                            wr_clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            Wr_full,
  output logic                            Wr_en,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state;
  logic [GW-1:0]   last_grant;
  logic [CW-1:0]   beat_cnt;

  logic [GW-1:0]   pick;
  logic            any_valid;
  logic            sel_valid;
  logic            sel_last;
  logic            xfer;
  logic            burst_end;

  // Reset overrides the registered state so nothing leaks out while held.
  assign busy      = (state == BURST) & ~reset;
  assign any_valid = |req_valid;
  assign xfer      = busy & sel_valid & ~Wr_full;
  assign Wr_en     = xfer;
  assign burst_end = xfer & (sel_last | (beat_cnt == CW'(MAX_BURST - 1)));

  // Route the grantee's valid, last and data onto the FIFO side.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    wr_data   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_id == GW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        wr_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Only the grantee sees ready, and only when the FIFO can take a beat.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_ready[i] = busy & ~Wr_full & (grant_id == GW'(i));
    end
  end

  // Round-robin pick: scan downward so the nearest index after last_grant wins.
  always_comb begin
    int unsigned   cand;
    logic [GW-1:0] cidx;
    pick = '0;
    cand = 0;
    cidx = '0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      cand = (32'(last_grant) + 32'(k)) % NUM_REQ;
      cidx = GW'(cand);
      if (req_valid[cidx]) begin
        pick = cidx;
      end
    end
  end

  // Arbitration FSM: IDLE picks a grantee, BURST streams until last or limit.
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id <= pick;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (burst_end) begin
              state      <= IDLE;
              last_grant <= grant_id;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed vector table plus hand-written sequences
// for burst splitting, FIFO-full stalls, mid-burst reset and a random stream.
module tb_fifo_write_arbiter;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned MAX_BURST  = 8;

  logic        wr_clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        Wr_full;
  logic        Wr_en;
  logic [7:0]  wr_data;
  logic [1:0]  grant_id;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_write_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .wr_clk   (wr_clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .Wr_full  (Wr_full),
    .Wr_en    (Wr_en),
    .wr_data  (wr_data),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] lst;
    logic       full;
    logic       chk_g;
    logic       e_busy;
    logic       e_wen;
    logic [3:0] e_rdy;
    logic [1:0] e_gid;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] vld, input logic [3:0] lst,
                     input logic full, input logic chk_g, input logic e_busy,
                     input logic e_wen, input logic [3:0] e_rdy, input logic [1:0] e_gid,
                     input logic [7:0] e_data);
    vec_t v;
    v.rst = rst; v.vld = vld; v.lst = lst; v.full = full; v.chk_g = chk_g;
    v.e_busy = e_busy; v.e_wen = e_wen; v.e_rdy = e_rdy; v.e_gid = e_gid; v.e_data = e_data;
    vecs.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; req_last = '0; Wr_full = 1'b0;
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    int beat;
    int cur;
    int nb;
    int bc;
    int lens[3];
    logic prev_busy;
    logic [5:0] cnt[4];
    logic [3:0] hs;
    int total;

    reset = 1'b1; req_valid = '0; req_last = '0; Wr_full = 1'b0; req_data = '0;
    #1;

    // Table: round-robin order, idle hold, packet lock, stall.
    //   rst vld      lst      full chkg busy wen rdy      gid    data
    add(1, 4'b1111, 4'b1111, 0, 0, 0, 0, 4'b0000, 2'd0, 8'h00);
    add(0, 4'b1111, 4'b1111, 0, 1, 0, 0, 4'b0000, 2'd0, 8'h00);
    add(0, 4'b1111, 4'b1111, 0, 1, 1, 1, 4'b0001, 2'd0, 8'h11);
    add(0, 4'b1111, 4'b1111, 0, 1, 0, 0, 4'b0000, 2'd0, 8'h00);
    add(0, 4'b1111, 4'b1111, 0, 1, 1, 1, 4'b0010, 2'd1, 8'h22);
    add(0, 4'b1111, 4'b1111, 0, 1, 0, 0, 4'b0000, 2'd1, 8'h00);
    add(0, 4'b1111, 4'b1111, 0, 1, 1, 1, 4'b0100, 2'd2, 8'h33);
    add(0, 4'b1111, 4'b1111, 0, 1, 0, 0, 4'b0000, 2'd2, 8'h00);
    add(0, 4'b1111, 4'b1111, 0, 1, 1, 1, 4'b1000, 2'd3, 8'h44);
    add(0, 4'b1111, 4'b1111, 0, 1, 0, 0, 4'b0000, 2'd3, 8'h00);
    add(0, 4'b1111, 4'b1111, 0, 1, 1, 1, 4'b0001, 2'd0, 8'h11);
    add(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 4'b0000, 2'd0, 8'h00);
    add(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 4'b0000, 2'd0, 8'h00);
    add(0, 4'b0100, 4'b0000, 0, 1, 0, 0, 4'b0000, 2'd0, 8'h00);
    add(0, 4'b0100, 4'b0000, 0, 1, 1, 1, 4'b0100, 2'd2, 8'h33);
    add(0, 4'b1011, 4'b1111, 0, 1, 1, 0, 4'b0100, 2'd2, 8'h00);
    add(0, 4'b1011, 4'b1111, 0, 1, 1, 0, 4'b0100, 2'd2, 8'h00);
    add(0, 4'b0100, 4'b0100, 1, 1, 1, 0, 4'b0000, 2'd2, 8'h00);
    add(0, 4'b0100, 4'b0100, 0, 1, 1, 1, 4'b0100, 2'd2, 8'h33);
    add(0, 4'b1111, 4'b0000, 0, 1, 0, 0, 4'b0000, 2'd2, 8'h00);
    add(0, 4'b1111, 4'b0000, 0, 1, 1, 1, 4'b1000, 2'd3, 8'h44);

    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    foreach (vecs[i]) begin
      reset = vecs[i].rst; req_valid = vecs[i].vld; req_last = vecs[i].lst;
      Wr_full = vecs[i].full;
      #1;
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d wr_en", i), 32'(Wr_en), 32'(vecs[i].e_wen));
      chk($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      if (vecs[i].chk_g) chk($sformatf("vec%0d grant", i), 32'(grant_id), 32'(vecs[i].e_gid));
      if (vecs[i].e_wen) chk($sformatf("vec%0d data", i), 32'(wr_data), 32'(vecs[i].e_data));
      next_cycle();
    end

    // Requester 2 alone, 20-beat packet: expect bursts of 8, 8, 4.
    do_reset();
    beat = 0; cur = 0; nb = 0; prev_busy = 1'b0;
    lens[0] = 0; lens[1] = 0; lens[2] = 0;
    for (int c = 0; c < 200 && nb < 3; c++) begin
      req_valid = (beat < 20) ? 4'b0100 : 4'b0000;
      req_data[2*8 +: 8] = 8'(beat);
      req_last = (beat == 19) ? 4'b0100 : 4'b0000;
      #1;
      if (busy) chk("split grant", 32'(grant_id), 32'd2);
      if (Wr_en) begin
        chk("split data", 32'(wr_data), 32'(beat));
        beat++; cur++;
      end
      if (!busy && prev_busy) begin
        lens[nb] = cur; nb++; cur = 0;
      end
      prev_busy = busy;
      next_cycle();
    end
    chk("split bursts", 32'(nb), 32'd3);
    chk("split len0", 32'(lens[0]), 32'd8);
    chk("split len1", 32'(lens[1]), 32'd8);
    chk("split len2", 32'(lens[2]), 32'd4);

    // Requester 1, 6-beat packet, FIFO full for 3 cycles mid-burst.
    do_reset();
    beat = 0; bc = 0;
    for (int c = 0; c < 40 && beat < 6; c++) begin
      req_valid = 4'b0010;
      req_data[1*8 +: 8] = 8'hA0 + 8'(beat);
      req_last = (beat == 5) ? 4'b0010 : 4'b0000;
      Wr_full = 1'b0;
      #1;
      Wr_full = busy && (bc >= 2) && (bc <= 4);
      #1;
      if (Wr_full) begin
        chk("stall wr_en", 32'(Wr_en), 32'd0);
        chk("stall ready", 32'(req_ready), 32'd0);
        chk("stall beat_cnt", 32'(dut.beat_cnt), 32'd2);
      end
      if (Wr_en) begin
        chk("stall data", 32'(wr_data), 32'hA0 + 32'(beat));
        beat++;
      end
      if (busy) bc++;
      next_cycle();
    end
    Wr_full = 1'b0; req_valid = '0; req_last = '0;
    #1;
    chk("stall beats", 32'(beat), 32'd6);
    chk("stall cycles", 32'(bc), 32'd9);
    chk("stall idle after", 32'(busy), 32'd0);

    // Reset during beat 3 of requester 1's burst.
    do_reset();
    req_valid = 4'b0010; req_last = '0;
    next_cycle();
    #1; chk("rst burst grant", 32'(grant_id), 32'd1);
    chk("rst beat1", 32'(Wr_en), 32'd1);
    next_cycle();
    #1; chk("rst beat2", 32'(Wr_en), 32'd1);
    next_cycle();
    reset = 1'b1;
    #1;
    chk("rst held busy", 32'(busy), 32'd0);
    chk("rst held wr_en", 32'(Wr_en), 32'd0);
    chk("rst held ready", 32'(req_ready), 32'd0);
    next_cycle();
    reset = 1'b0; req_valid = 4'b0011;
    #1;
    chk("post rst busy", 32'(busy), 32'd0);
    chk("post rst wr_en", 32'(Wr_en), 32'd0);
    next_cycle();
    #1;
    chk("post rst busy2", 32'(busy), 32'd1);
    chk("post rst grant", 32'(grant_id), 32'd0);

    // Random stream: per-requester sequence numbers must reach the FIFO in order.
    do_reset();
    for (int i = 0; i < 4; i++) cnt[i] = '0;
    total = 0;
    for (int c = 0; c < 600; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_last = '0;
      for (int i = 0; i < 4; i++) begin
        req_data[i*8 +: 8] = {2'(i), cnt[i]};
        req_last[i] = ($urandom_range(0, 3) == 0);
      end
      Wr_full = ($urandom_range(0, 4) == 0);
      #1;
      hs = req_ready & req_valid;
      chk("rand wr_en", 32'(Wr_en), 32'(|hs));
      chk("rand onehot", 32'($countones(req_ready)), 32'(busy && !Wr_full));
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) begin
          chk("rand fifo data", 32'(wr_data), 32'({2'(i), cnt[i]}));
          cnt[i] = cnt[i] + 6'd1;
          total++;
        end
      end
      next_cycle();
    end
    n_checks++;
    if (total < 50) begin
      n_fail++;
      $display("FAIL rand throughput: got %0d transfers expected at least 50", total);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
